time_set_ctrl: RTL and testbench

- Sequencing controller for the six-digit BCD hh:mm:ss counter bank.
- In RUN it converts a 1 Hz tick into the three per-field count enables, and generates the minute/hour cascade from the current time.
- In SET it freezes the counters and lets the user edit hour, minute and second in shadow registers.
- On commit it drives a one-cycle load of all six digits.

---
 rtl/time_set_ctrl_pkg.sv | 31 +++
 rtl/time_set_ctrl_bcd2_inc.sv | 31 +++
 rtl/time_set_ctrl.sv | 162 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the hh:mm:ss time-set controller.
// Field indices address the per-field edit registers: 0 = hour, 1 = minute, 2 = second.
package time_set_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_COMMIT   = 3'd4
    } state_t;

    localparam logic [3:0] ZERO  = 4'd0;
    localparam logic [3:0] TWO   = 4'd2;
    localparam logic [3:0] THREE = 4'd3;
    localparam logic [3:0] FIVE  = 4'd5;
    localparam logic [3:0] NINE  = 4'd9;

    localparam logic [7:0] HOUR_MAX   = {TWO, THREE};
    localparam logic [7:0] MINSEC_MAX = {FIVE, NINE};

    localparam int FLD_HOUR = 0;
    localparam int FLD_MIN  = 1;
    localparam int FLD_SEC  = 2;

    function automatic logic field_is(input logic [3:0] tens, input logic [3:0] units,
                                      input logic [7:0] value);
        return {tens, units} == value;
    endfunction

endpackage

// File: rtl/time_set_ctrl_bcd2_inc.sv
// Combinational two-digit BCD incrementer with wrap to 00 at the field maximum.
// Any value at or beyond the maximum, or with a non-BCD units digit, also wraps to 00.
module bcd2_inc
    import time_set_ctrl_pkg::*;
(
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic [3:0] tens_max,
    input  logic [3:0] units_max_at_tens_max,
    output logic [3:0] tens_next,
    output logic [3:0] units_next
);

    logic wrap;

    assign wrap = (tens > tens_max) || (units > NINE) ||
                  ((tens == tens_max) && (units >= units_max_at_tens_max));

    always_comb begin
        tens_next  = tens;
        units_next = units + 4'd1;
        if (wrap) begin
            tens_next  = ZERO;
            units_next = ZERO;
        end else if (units == NINE) begin
            tens_next  = tens + 4'd1;
            units_next = ZERO;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Run/set sequencer for the BCD hh:mm:ss counter bank: cascades count enables in RUN,
// edits shadow hour/minute/second registers in SET, and strobes a load on commit.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 30,
    parameter int BLINK_TICKS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [3:0] cur_sec0,
    input  logic [3:0] cur_sec1,
    input  logic [3:0] cur_min0,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_hour0,
    input  logic [3:0] cur_hour1,
    output logic [2:0] count_enable,
    output logic       load_value_enable,
    output logic [3:0] ld_sec0,
    output logic [3:0] ld_sec1,
    output logic [3:0] ld_min0,
    output logic [3:0] ld_min1,
    output logic [3:0] ld_hour0,
    output logic [3:0] ld_hour1,
    output logic [2:0] mode,
    output logic       blink
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);
    localparam logic [7:0] BLINK_LAST   = 8'(BLINK_TICKS - 1);

    state_t     state_reg;
    logic [2:0] mode_reg;
    logic       load_reg;
    logic [7:0] timeout_reg;
    logic [7:0] blink_cnt_reg;
    logic       blink_phase_reg;
    logic       blink_force_reg;
    logic [3:0] tens_reg  [3];
    logic [3:0] units_reg [3];
    logic [3:0] tens_inc  [3];
    logic [3:0] units_inc [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_inc
            bcd2_inc u_inc (
                .tens                  (tens_reg[gi]),
                .units                 (units_reg[gi]),
                .tens_max              ((gi == FLD_HOUR) ? HOUR_MAX[7:4] : MINSEC_MAX[7:4]),
                .units_max_at_tens_max ((gi == FLD_HOUR) ? HOUR_MAX[3:0] : MINSEC_MAX[3:0]),
                .tens_next             (tens_inc[gi]),
                .units_next            (units_inc[gi])
            );
        end
    endgenerate

    always_comb begin
        count_enable = 3'b000;
        if (state_reg == ST_RUN) begin
            count_enable[0] = sec_tick;
            count_enable[1] = sec_tick && field_is(cur_sec1, cur_sec0, MINSEC_MAX);
            count_enable[2] = count_enable[1] && field_is(cur_min1, cur_min0, MINSEC_MAX);
        end
    end

    // mode_reg is one-hot over the field index, so it doubles as the edit-field select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_RUN;
            mode_reg        <= 3'b000;
            load_reg        <= 1'b0;
            timeout_reg     <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            blink_force_reg <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                tens_reg[i]  <= ZERO;
                units_reg[i] <= ZERO;
            end
        end else begin
            load_reg        <= 1'b0;
            blink_force_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= 1'b0;
                    if (mode_btn) begin
                        state_reg           <= ST_SET_HOUR;
                        mode_reg            <= 3'b001;
                        timeout_reg         <= '0;
                        tens_reg[FLD_HOUR]  <= cur_hour1;
                        units_reg[FLD_HOUR] <= cur_hour0;
                        tens_reg[FLD_MIN]   <= cur_min1;
                        units_reg[FLD_MIN]  <= cur_min0;
                        tens_reg[FLD_SEC]   <= cur_sec1;
                        units_reg[FLD_SEC]  <= cur_sec0;
                    end
                end
                ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
                    if (sec_tick) begin
                        if (blink_cnt_reg == BLINK_LAST) begin
                            blink_cnt_reg   <= '0;
                            blink_phase_reg <= !blink_phase_reg;
                        end else begin
                            blink_cnt_reg <= blink_cnt_reg + 8'd1;
                        end
                    end
                    if (mode_btn) begin
                        timeout_reg <= '0;
                        mode_reg    <= {mode_reg[1:0], 1'b0};
                        case (state_reg)
                            ST_SET_HOUR: state_reg <= ST_SET_MIN;
                            ST_SET_MIN:  state_reg <= ST_SET_SEC;
                            default: begin
                                state_reg <= ST_COMMIT;
                                load_reg  <= 1'b1;
                            end
                        endcase
                    end else if (inc_btn) begin
                        timeout_reg     <= '0;
                        blink_force_reg <= 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            if (mode_reg[i]) begin
                                tens_reg[i]  <= tens_inc[i];
                                units_reg[i] <= units_inc[i];
                            end
                        end
                    end else if (sec_tick) begin
                        if (timeout_reg == TIMEOUT_LAST) begin
                            state_reg   <= ST_RUN;
                            mode_reg    <= 3'b000;
                            timeout_reg <= '0;
                        end else begin
                            timeout_reg <= timeout_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg       <= ST_RUN;
                    mode_reg        <= 3'b000;
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= 1'b0;
                end
            endcase
        end
    end

    assign load_value_enable = load_reg;
    assign mode              = mode_reg;
    assign blink             = (|mode_reg) && (blink_phase_reg || blink_force_reg);

    assign ld_hour1 = tens_reg[FLD_HOUR];
    assign ld_hour0 = units_reg[FLD_HOUR];
    assign ld_min1  = tens_reg[FLD_MIN];
    assign ld_min0  = units_reg[FLD_MIN];
    assign ld_sec1  = tens_reg[FLD_SEC];
    assign ld_sec0  = units_reg[FLD_SEC];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized and directed bench for time_set_ctrl against an integer-valued behavioural model
// of the clock-setting rules (times as plain hour/minute/second numbers).
module tb_time_set_ctrl;

    localparam int TIMEOUT = 30;
    localparam int BLINK   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [3:0] cur_sec0 = '0, cur_sec1 = '0, cur_min0 = '0, cur_min1 = '0;
    logic [3:0] cur_hour0 = '0, cur_hour1 = '0;
    logic [2:0] count_enable;
    logic       load_value_enable;
    logic [3:0] ld_sec0, ld_sec1, ld_min0, ld_min1, ld_hour0, ld_hour1;
    logic [2:0] mode;
    logic       blink;

    time_set_ctrl #(.TIMEOUT_TICKS(TIMEOUT), .BLINK_TICKS(BLINK)) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .cur_sec0(cur_sec0), .cur_sec1(cur_sec1), .cur_min0(cur_min0), .cur_min1(cur_min1),
        .cur_hour0(cur_hour0), .cur_hour1(cur_hour1),
        .count_enable(count_enable), .load_value_enable(load_value_enable),
        .ld_sec0(ld_sec0), .ld_sec1(ld_sec1), .ld_min0(ld_min0), .ld_min1(ld_min1),
        .ld_hour0(ld_hour0), .ld_hour1(ld_hour1), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN, 3 = SET_SEC, 4 = COMMIT
    int m_state = 0;
    int m_f [3] = '{0, 0, 0};
    int m_to = 0, m_bcnt = 0, m_phase = 0, m_force = 0;
    int cur_h = 0, cur_m = 0, cur_s = 0;

    logic [23:0] ld_all;
    assign ld_all = {ld_hour1, ld_hour0, ld_min1, ld_min0, ld_sec1, ld_sec0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic model_edge(input bit r, input bit t, input bit mb, input bit ib);
        if (r) begin
            m_state = 0; m_f = '{0, 0, 0};
            m_to = 0; m_bcnt = 0; m_phase = 0; m_force = 0;
            return;
        end
        if (m_state == 0) begin
            m_bcnt = 0; m_phase = 0; m_force = 0;
            if (mb) begin
                m_state = 1; m_to = 0;
                m_f = '{cur_h, cur_m, cur_s};
            end
        end else if (m_state <= 3) begin
            m_force = 0;
            if (t) begin
                m_bcnt++;
                if (m_bcnt == BLINK) begin m_bcnt = 0; m_phase ^= 1; end
            end
            if (mb) begin
                m_to = 0;
                m_state++;
            end else if (ib) begin
                m_to = 0; m_force = 1;
                m_f[m_state - 1] = (m_f[m_state - 1] + 1) % ((m_state == 1) ? 24 : 60);
            end else if (t) begin
                m_to++;
                if (m_to == TIMEOUT) begin m_state = 0; m_to = 0; end
            end
        end else begin
            m_state = 0; m_bcnt = 0; m_phase = 0; m_force = 0;
        end
    endtask

    // One clock: drive inputs after negedge, compare everything against the model, advance model.
    task automatic step(input bit r, input bit t, input bit mb, input bit ib);
        logic [2:0] exp_ce, exp_mode;
        @(negedge clk);
        rst = r; sec_tick = t; mode_btn = mb; inc_btn = ib;
        {cur_hour1, cur_hour0} = to_bcd(cur_h);
        {cur_min1, cur_min0}   = to_bcd(cur_m);
        {cur_sec1, cur_sec0}   = to_bcd(cur_s);
        #1;
        exp_ce = '0;
        if (m_state == 0 && t) begin
            exp_ce[0] = 1'b1;
            exp_ce[1] = (cur_s == 59);
            exp_ce[2] = (cur_s == 59) && (cur_m == 59);
        end
        exp_mode = (m_state >= 1 && m_state <= 3) ? 3'(1 << (m_state - 1)) : 3'b000;
        check_eq("count_enable", 32'(count_enable), 32'(exp_ce));
        check_eq("mode", 32'(mode), 32'(exp_mode));
        check_eq("load_value_enable", 32'(load_value_enable), 32'(m_state == 4));
        check_eq("ld_digits", 32'(ld_all), 32'({to_bcd(m_f[0]), to_bcd(m_f[1]), to_bcd(m_f[2])}));
        check_eq("blink", 32'(blink),
                 32'((exp_mode != 0) && (m_phase != 0 || m_force != 0)));
        model_edge(r, t, mb, ib);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("reset_mode", 32'(mode), 32'h0);
        check_eq("reset_load", 32'(load_value_enable), 32'h0);
        check_eq("reset_ld", 32'(ld_all), 32'h0);
        check_eq("reset_blink", 32'(blink), 32'h0);

        // RUN cascade
        cur_h = 12; cur_m = 34; cur_s = 58; step(0, 1, 0, 0);
        check_eq("ce_sec_only", 32'(count_enable), 32'b001);
        cur_s = 59; step(0, 1, 0, 0);
        check_eq("ce_sec_min", 32'(count_enable), 32'b011);
        cur_m = 59; step(0, 1, 0, 0);
        check_eq("ce_all", 32'(count_enable), 32'b111);

        // Full edit from 23:59:59 and commit
        cur_h = 23; cur_m = 59; cur_s = 59;
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        check_eq("captured", 32'(ld_all), 32'h235959);
        step(0, 0, 1, 0);
        check_eq("hour_wrap", 32'(ld_all), 32'h005959);
        check_eq("blink_forced", 32'(blink), 32'h1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        check_eq("min_wrap", 32'(ld_all), 32'h000059);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        check_eq("sec_inc2", 32'(ld_all), 32'h000001);
        step(0, 0, 0, 0);
        check_eq("commit_load", 32'(load_value_enable), 32'h1);
        check_eq("commit_ld", 32'(ld_all), 32'h000001);
        step(0, 0, 0, 0);
        check_eq("after_commit_load", 32'(load_value_enable), 32'h0);
        check_eq("after_commit_mode", 32'(mode), 32'h0);

        // Frozen in SET_MIN, then tens carry 09 -> 10
        cur_h = 10; cur_m = 9; cur_s = 30;
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 15; i++) begin
            step(0, 1, 0, 0);
            check_eq("frozen_ce", 32'(count_enable), 32'h0);
        end
        step(0, 0, 0, 1);
        check_eq("still_set_min", 32'(mode), 32'b010);
        step(0, 0, 0, 0);
        check_eq("min_carry", 32'(ld_all[15:8]), 32'h10);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        idle(2);

        // Timeout abandons SET without a load
        step(0, 0, 1, 0);
        for (int i = 0; i < TIMEOUT; i++) begin
            step(0, 1, 0, 0);
            check_eq("timeout_no_load", 32'(load_value_enable), 32'h0);
        end
        step(0, 0, 0, 0);
        check_eq("timeout_mode", 32'(mode), 32'h0);
        check_eq("timeout_load", 32'(load_value_enable), 32'h0);

        // Button on the terminal tick keeps SET
        step(0, 0, 1, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        check_eq("timeout_blocked", 32'(mode), 32'b001);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        idle(2);

        // mode+inc together: mode wins, hour untouched; then rst during COMMIT
        cur_h = 7; cur_m = 0; cur_s = 0;
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        check_eq("mode_wins", 32'(mode), 32'b010);
        check_eq("hour_kept", 32'(ld_all[23:16]), 32'h07);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("rst_commit_load", 32'(load_value_enable), 32'h0);
        check_eq("rst_commit_mode", 32'(mode), 32'h0);
        check_eq("rst_commit_ce", 32'(count_enable), 32'h0);
        check_eq("rst_commit_ld", 32'(ld_all), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cur_h = $urandom_range(0, 23);
            cur_m = ($urandom_range(0, 3) == 0) ? 59 : $urandom_range(0, 59);
            cur_s = ($urandom_range(0, 2) == 0) ? 59 : $urandom_range(0, 59);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
